// File: rtl/bf_pkg.sv
// Shared definitions for the bfloat16 multiplier pipeline.
// Holds the operand-class enum, the default format constants and a helper
// that builds the canonical quiet-NaN bit pattern for any exponent/fraction
// width combination.
package bf_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } bf_class_e;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 7;
  localparam int DEF_BIAS  = 2 ** (DEF_EXP_W - 1) - 1;

  // Canonical NaN: sign 0, exponent all ones, only the fraction MSB set.
  // Returned in a wide vector so callers can slice out their own width.
  function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bf_unpack.sv
// Splits one floating-point operand into sign, biased exponent and mantissa
// (with the hidden bit restored) and classifies it.
// Subnormals are flushed: exp==0 is always ZERO and its mantissa reads as 0.
// Ports:
//   x     - packed operand {sign, exp, frac}
//   sign  - operand sign bit
//   exp   - biased exponent field
//   mant  - {hidden, frac}, zero for ZERO-class operands
//   cls   - ZERO / NORM / INF / NAN
module bf_unpack
  import bf_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  localparam int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic [WIDTH-1:0] x,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W:0]   mant,
  output bf_class_e        cls
);

  logic [MAN_W-1:0] frac;
  logic             exp_zero;
  logic             exp_ones;

  assign sign     = x[WIDTH-1];
  assign exp      = x[WIDTH-2 -: EXP_W];
  assign frac     = x[MAN_W-1:0];
  assign exp_zero = (exp == '0);
  assign exp_ones = (exp == '1);

  // Classification; the hidden bit is only restored for normal numbers so
  // that flushed subnormals contribute a clean zero mantissa downstream.
  always_comb begin
    cls  = NORM;
    mant = {1'b1, frac};
    if (exp_zero) begin
      cls  = ZERO;
      mant = '0;
    end else if (exp_ones) begin
      cls = (frac == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/bfloat16_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (bfloat16 by default).
//   S1: unpack/classify both operands, xor signs, exponent sum ea+eb-BIAS
//   S2: unsigned mantissa product
//   S3: normalise, round-to-nearest-even, pack, raise flags (output register)
// Valid/ready handshaking on both sides with combinational backpressure, so
// a full pipeline still accepts one pair per cycle when the consumer drains.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   in_valid, in_ready   - input handshake for operand pair a/b
//   a, b                 - operands {sign, exp, frac}
//   out_valid, out_ready - output handshake
//   result               - product
//   flags                - {invalid, overflow, underflow}, aligned with result
module bfloat16_mul_pipe
  import bf_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int BIAS  = 2 ** (EXP_W - 1) - 1,
  localparam int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;

  localparam logic [63:0]          NAN_WIDE = canonical_nan(EXP_W, MAN_W);
  localparam logic [WIDTH-1:0]     NAN_PAT  = NAN_WIDE[WIDTH-1:0];
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_NIL  = '0;
  localparam logic signed [EW-1:0] BIAS_EW  = EW'(BIAS);

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   ma, mb;
  bf_class_e        ca, cb;

  bf_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x(a), .sign(sa), .exp(ea), .mant(ma), .cls(ca)
  );

  bf_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x(b), .sign(sb), .exp(eb), .mant(mb), .cls(cb)
  );

  logic                 s1_valid, s2_valid;
  logic                 s1_sign, s2_sign;
  bf_class_e            s1_kind, s2_kind;
  logic signed [EW-1:0] s1_exp, s2_exp;
  logic [MAN_W:0]       s1_ma, s1_mb;
  logic [PW-1:0]        s2_prod;

  logic s1_load, s2_load, s3_load;

  // Each stage loads when empty or when its current contents leave this
  // cycle; this chains the consumer's ready back to the input combinationally.
  assign s3_load  = !out_valid || out_ready;
  assign s2_load  = !s2_valid || s3_load;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load && !rst;

  // The result class is settled in S1 so later stages only carry one tag:
  // NaN inputs and inf*zero are invalid, otherwise inf dominates zero.
  bf_class_e            kind_c;
  logic signed [EW-1:0] exp_sum_c;

  always_comb begin
    kind_c = NORM;
    if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
      kind_c = NAN;
    end else if (ca == INF || cb == INF) begin
      kind_c = INF;
    end else if (ca == ZERO || cb == ZERO) begin
      kind_c = ZERO;
    end
  end

  assign exp_sum_c = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_EW;

  // Stage valid bits are the only pipeline state that needs reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s2_load) s2_valid <= s1_valid;
    end
  end

  // Stage 1 payload: captured only on an actual input transfer.
  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_sign <= sa ^ sb;
      s1_kind <= kind_c;
      s1_exp  <= exp_sum_c;
      s1_ma   <= ma;
      s1_mb   <= mb;
    end
  end

  // Stage 2 payload: the full-width mantissa product.
  always_ff @(posedge clk) begin
    if (s2_load && s1_valid) begin
      s2_sign <= s1_sign;
      s2_kind <= s1_kind;
      s2_exp  <= s1_exp;
      s2_prod <= {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};
    end
  end

  // Stage 3 combinational: the product of two [1,2) mantissas lies in [1,4),
  // so at most one right shift is needed. Guard is the first dropped bit and
  // sticky ORs everything below it; a rounding carry-out wraps the fraction
  // to zero and bumps the exponent.
  logic [MAN_W-1:0]     frac_t, frac_f;
  logic [MAN_W:0]       frac_r;
  logic                 guard, sticky, round_up;
  logic signed [EW-1:0] exp_n, exp_f;
  logic [WIDTH-1:0]     result_c;
  logic [2:0]           flags_c;

  always_comb begin
    frac_t = s2_prod[2*MAN_W-1 -: MAN_W];
    guard  = s2_prod[MAN_W-1];
    sticky = |s2_prod[MAN_W-2:0];
    exp_n  = s2_exp;
    if (s2_prod[PW-1]) begin
      frac_t = s2_prod[2*MAN_W -: MAN_W];
      guard  = s2_prod[MAN_W];
      sticky = |s2_prod[MAN_W-1:0];
      exp_n  = s2_exp + EXP_ONE;
    end
    round_up = guard && (sticky || frac_t[0]);
    frac_r   = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
    frac_f   = frac_r[MAN_W-1:0];
    exp_f    = frac_r[MAN_W] ? exp_n + EXP_ONE : exp_n;

    result_c = {s2_sign, {(WIDTH-1){1'b0}}};
    flags_c  = 3'b000;
    case (s2_kind)
      NAN: begin
        result_c = NAN_PAT;
        flags_c  = 3'b100;
      end
      INF: begin
        result_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      ZERO: begin
        result_c = {s2_sign, {(WIDTH-1){1'b0}}};
      end
      default: begin
        if (exp_f >= EXP_MAX) begin
          result_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_c  = 3'b010;
        end else if (exp_f <= EXP_NIL) begin
          result_c = {s2_sign, {(WIDTH-1){1'b0}}};
          flags_c  = 3'b001;
        end else begin
          result_c = {s2_sign, exp_f[EXP_W-1:0], frac_f};
        end
      end
    endcase
  end

  // Output register: holds result and flags steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (s3_load) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result <= result_c;
        flags  <= flags_c;
      end
    end
  end

endmodule
